// File: rtl/muldiv_unit_if.sv
//==============================================================================
// Module : muldiv_unit_if
// Brief  : Request/result bundle between EX-stage control and the mul/div unit.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, x, y, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, x, y, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
//==============================================================================
// Module : muldiv_unit
// Brief  : Radix-2 multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic      clk,
    input  wire logic      rst,
    muldiv_unit_if.slave   bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DZ   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [1:0]         r_op;
    logic               r_sx;
    logic               r_sy;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dbz;

    logic               w_signed_new;
    logic               w_x_neg;
    logic               w_y_neg;
    logic [WIDTH-1:0]   w_x_mag;
    logic [WIDTH-1:0]   w_y_mag;
    logic               w_y_zero;

    logic               w_sub;
    logic [WIDTH+1:0]   w_opa;
    logic [WIDTH+1:0]   w_opb;
    logic [WIDTH+1:0]   w_addsub;
    logic [2*WIDTH-1:0] w_acc_step;

    logic               w_res_neg;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_lo_div;
    logic [WIDTH-1:0]   w_hi_div;

    // Operand conditioning at issue: signed ops (op[0]==0) work on magnitudes.
    assign w_signed_new = ~bus.op[0];
    assign w_x_neg      = w_signed_new & bus.x[WIDTH-1];
    assign w_y_neg      = w_signed_new & bus.y[WIDTH-1];
    assign w_x_mag      = w_x_neg ? -bus.x : bus.x;
    assign w_y_mag      = w_y_neg ? -bus.y : bus.y;
    assign w_y_zero     = (bus.y == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = (bus.op[1] && w_y_zero) ? S_DZ : S_CALC;
                end
            end
            S_CALC: begin
                if (r_count == c_last) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX:   w_state_next = S_IDLE;
            S_DZ:    w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // One shared adder: multiply adds the multiplicand to the upper half,
    // divide trial-subtracts the divisor from the left-shifted remainder.
    always_comb begin
        w_sub = r_op[1];
        w_opb = {2'b00, r_b};
        if (r_op[1]) begin
            w_opa = {1'b0, r_acc[2*WIDTH-1:WIDTH-1]};
        end else begin
            w_opa = {2'b00, r_acc[2*WIDTH-1:WIDTH]};
        end
    end

    assign w_addsub = w_opa + (w_sub ? ~w_opb : w_opb) + {{(WIDTH+1){1'b0}}, w_sub};

    always_comb begin
        w_acc_step = r_acc;
        if (r_op[1]) begin
            if (!w_addsub[WIDTH+1]) begin
                w_acc_step = {w_addsub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_step = {r_acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            if (r_acc[0]) begin
                w_acc_step = {w_addsub[WIDTH:0], r_acc[WIDTH-1:1]};
            end else begin
                w_acc_step = {1'b0, r_acc[2*WIDTH-1:1]};
            end
        end
    end

    // Sign fix-up; remainder follows the dividend sign.
    assign w_res_neg = r_sx ^ r_sy;
    assign w_prod    = w_res_neg ? -r_acc : r_acc;
    assign w_quo     = r_acc[WIDTH-1:0];
    assign w_rem     = r_acc[2*WIDTH-1:WIDTH];
    assign w_lo_div  = w_res_neg ? -w_quo : w_quo;
    assign w_hi_div  = r_sx ? -w_rem : w_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= 2'b00;
            r_sx    <= 1'b0;
            r_sy    <= 1'b0;
            r_count <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.hi_we) begin
                        r_hi <= bus.wdata;
                    end
                    if (bus.lo_we) begin
                        r_lo <= bus.wdata;
                    end
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_sx    <= w_x_neg;
                        r_sy    <= w_y_neg;
                        r_b     <= w_y_mag;
                        r_acc   <= {{WIDTH{1'b0}}, w_x_mag};
                        r_count <= '0;
                    end
                end
                S_CALC: begin
                    r_acc   <= w_acc_step;
                    r_count <= r_count + 1'b1;
                end
                S_FIX: begin
                    if (r_op[1]) begin
                        r_hi <= w_hi_div;
                        r_lo <= w_lo_div;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done <= 1'b1;
                end
                S_DZ: begin
                    r_done <= 1'b1;
                    r_dbz  <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
//==============================================================================
// Module : tb_muldiv_unit
// Brief  : Self-checking bench for muldiv_unit against an arithmetic model.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_muldiv_unit;

    logic clk;
    logic rst;
    logic chk_en;
    int   n_tests;
    int   n_fail;
    int   cycle;

    muldiv_unit_if #(.WIDTH(32)) bus();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Architectural result from plain integer arithmetic: {hi, lo}
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, uq, ur, r;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (o)
            2'b00: r = 64'(sa * sb);
            2'b01: r = ua * ub;
            2'b10: begin
                sq = sa / sb;
                sr = sa % sb;
                r  = {sr[31:0], sq[31:0]};
            end
            default: begin
                uq = ua / ub;
                ur = ua % ub;
                r  = {ur[31:0], uq[31:0]};
            end
        endcase
        return r;
    endfunction

    // Transaction-level model: an accepted op completes a fixed number of
    // edges later (33, or 1 for divide by zero); HI/LO writes only when idle.
    int          m_remain;
    logic        m_pend_dz;
    logic [31:0] m_res_hi, m_res_lo, m_hi, m_lo;
    logic        m_done, m_dbz;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_remain  <= 0;
            m_pend_dz <= 1'b0;
            m_res_hi  <= '0;
            m_res_lo  <= '0;
            m_hi      <= '0;
            m_lo      <= '0;
            m_done    <= 1'b0;
            m_dbz     <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            if (m_remain == 0) begin
                if (bus.hi_we) m_hi <= bus.wdata;
                if (bus.lo_we) m_lo <= bus.wdata;
                if (bus.start) begin
                    if (bus.op[1] && bus.y == 32'h0) begin
                        m_remain  <= 1;
                        m_pend_dz <= 1'b1;
                    end else begin
                        m_remain  <= 33;
                        m_pend_dz <= 1'b0;
                        {m_res_hi, m_res_lo} <= ref_result(bus.op, bus.x, bus.y);
                    end
                end
            end else begin
                m_remain <= m_remain - 1;
                if (m_remain == 1) begin
                    m_done <= 1'b1;
                    m_dbz  <= m_pend_dz;
                    if (!m_pend_dz) begin
                        m_hi <= m_res_hi;
                        m_lo <= m_res_lo;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 64'(bus.busy), 64'(m_remain != 0));
            check("done", 64'(bus.done), 64'(m_done));
            check("div_by_zero", 64'(bus.div_by_zero), 64'(m_dbz));
            check("hi", 64'(bus.hi), 64'(m_hi));
            check("lo", 64'(bus.lo), 64'(m_lo));
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic hw, input logic lw, input logic [31:0] wd);
        @(posedge clk); #2;
        bus.start = 1'b1; bus.op = o; bus.x = a; bus.y = b;
        bus.hi_we = hw; bus.lo_we = lw; bus.wdata = wd;
        @(posedge clk); #2;
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    endtask

    // Returns edges after the start edge until done is seen, busy cycles seen
    // on the way, and the divide-by-zero flag in the done cycle.
    task automatic wait_done(output int cyc, output int busy_cnt, output logic dz);
        cyc = 0; busy_cnt = 0; dz = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                dz = bus.div_by_zero;
                return;
            end
            cyc++;
        end
        n_tests++;
        n_fail++;
        $display("FAIL timeout: done not seen within 60 cycles, got none required done");
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        int   bc;
        logic dz;
        issue(o, a, b, 1'b0, 1'b0, 32'h0);
        wait_done(cyc, bc, dz);
    endtask

    task automatic idle_write(input logic hw, input logic lw, input logic [31:0] wd);
        @(posedge clk); #2;
        bus.hi_we = hw; bus.lo_we = lw; bus.wdata = wd;
        @(posedge clk); #2;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          cyc, bc, t1, t2;
        logic        dz;
        logic [1:0]  o;
        logic [31:0] a, b;

        n_tests = 0; n_fail = 0; cycle = 0; chk_en = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.x = '0; bus.y = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        rst = 1'b1;
        #1;
        check("reset_busy", 64'(bus.busy), 64'h0);
        check("reset_done", 64'(bus.done), 64'h0);
        check("reset_hi", 64'(bus.hi), 64'h0);
        check("reset_lo", 64'(bus.lo), 64'h0);

        check("model_mult", ref_result(2'b00, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
        check("model_multu", ref_result(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        check("model_div", ref_result(2'b10, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        check("model_divovf", ref_result(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk_en = 1'b1;

        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, cyc);
        check("mult_latency", 64'(cyc), 64'd33);
        check("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(bus.lo), 64'hFFFF_FFF1);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        check("multu_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        check("multu_lo", 64'(bus.lo), 64'h0000_0001);

        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, cyc);
        check("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);

        run_op(2'b11, 32'd100, 32'd7, cyc);
        check("divu_lo", 64'(bus.lo), 64'h0000_000E);
        check("divu_hi", 64'(bus.hi), 64'h0000_0002);

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        check("divovf_lo", 64'(bus.lo), 64'h8000_0000);
        check("divovf_hi", 64'(bus.hi), 64'h0000_0000);

        idle_write(1'b1, 1'b0, 32'h1111_1111);
        idle_write(1'b0, 1'b1, 32'h2222_2222);
        issue(2'b11, 32'd55, 32'd0, 1'b0, 1'b0, 32'h0);
        wait_done(cyc, bc, dz);
        check("dz_latency", 64'(cyc), 64'd1);
        check("dz_flag", 64'(dz), 64'd1);
        check("dz_busy_cycles", 64'(bc), 64'd1);
        check("dz_hi", 64'(bus.hi), 64'h1111_1111);
        check("dz_lo", 64'(bus.lo), 64'h2222_2222);

        issue(2'b00, 32'd6, 32'd7, 1'b0, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #2;
        bus.start = 1'b1; bus.op = 2'b11; bus.x = 32'd99; bus.y = 32'd3;
        bus.hi_we = 1'b1; bus.wdata = 32'h0000_DEAD;
        @(posedge clk); #2;
        bus.start = 1'b0; bus.hi_we = 1'b0;
        wait_done(cyc, bc, dz);
        check("busyprot_hi", 64'(bus.hi), 64'h0);
        check("busyprot_lo", 64'(bus.lo), 64'd42);

        run_op(2'b01, 32'd3, 32'd4, cyc);
        t1 = cycle;
        bus.start = 1'b1; bus.op = 2'b10; bus.x = 32'hFFFF_FF9C; bus.y = 32'd7;
        @(posedge clk); #2;
        bus.start = 1'b0;
        wait_done(cyc, bc, dz);
        t2 = cycle;
        check("b2b_spacing", 64'(t2 - t1), 64'd34);
        check("b2b_lo", 64'(bus.lo), 64'hFFFF_FFF2);
        check("b2b_hi", 64'(bus.hi), 64'hFFFF_FFFE);

        issue(2'b00, 32'd12345, 32'd678, 1'b0, 1'b0, 32'h0);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(bus.busy), 64'h0);
        check("arst_done", 64'(bus.done), 64'h0);
        check("arst_hi", 64'(bus.hi), 64'h0);
        check("arst_lo", 64'(bus.lo), 64'h0);
        @(posedge clk); #2 rst = 1'b0;
        run_op(2'b00, 32'd9, 32'hFFFF_FFFE, cyc);
        check("post_rst_latency", 64'(cyc), 64'd33);
        check("post_rst_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("post_rst_lo", 64'(bus.lo), 64'hFFFF_FFEE);

        for (int n = 0; n < 60; n++) begin
            o = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            if ($urandom_range(0, 3) == 0) idle_write(1'($urandom), 1'($urandom), $urandom);
            issue(o, a, b, 1'($urandom), 1'($urandom), $urandom);
            if (!(o[1] && b == 32'h0) && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 20)) @(posedge clk);
                #2;
                bus.start = 1'b1; bus.op = 2'($urandom); bus.x = $urandom; bus.y = $urandom;
                bus.hi_we = 1'($urandom); bus.lo_we = 1'($urandom); bus.wdata = $urandom;
                @(posedge clk); #2;
                bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
            end
            wait_done(cyc, bc, dz);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
